// File: rtl/hyperram_ctrl.sv
// Single-word HyperBus controller: turns SRAM-style 16-bit requests into CS#/CA/latency/data
// phases, emitting DDR-split pad data and direction enables for an external iCE40 I/O wrapper.
module hyperram_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 6,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  sram_req,
    input  logic                  sram_rd,
    output logic                  sram_ready,
    input  logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [15:0]           sram_wr_data,
    output logic                  sram_rd_data_vld,
    output logic [15:0]           sram_rd_data,
    output logic                  hyperram_io_clk,
    output logic                  hyperram_clk,
    output logic                  hyperram_ce_to_pad_,
    output logic                  hyperram_rst_to_pad_,
    output logic                  hyperram_dq_dir,
    output logic                  hyperram_rwds_dir,
    output logic [7:0]            hyperram_dq_to_pad_0,
    output logic [7:0]            hyperram_dq_to_pad_1,
    output logic                  hyperram_rwds_to_pad_0,
    output logic                  hyperram_rwds_to_pad_1,
    input  logic [7:0]            hyperram_dq_from_pad_0,
    input  logic [7:0]            hyperram_dq_from_pad_1,
    input  logic                  hyperram_rwds_from_pad_0,
    input  logic                  hyperram_rwds_from_pad_1
);

    // state    | meaning
    // IDLE     | CS# high, ready for a request
    // CSSETUP  | CS# low one cycle before CK starts
    // CA       | three command/address DDR words
    // WAIT     | fixed 2x initial latency, bus released
    // WDATA    | one DDR write word, RWDS driven low (no mask)
    // RDATA    | wait for RWDS strobe, bounded by RD_TIMEOUT
    // RECOVER  | CS# high two cycles before next access
    typedef enum logic [2:0] {
        S_IDLE, S_CSSETUP, S_CA, S_WAIT, S_WDATA, S_RDATA, S_RECOVER
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [47:0] ca_q;
    logic [47:0] ca_nxt;
    logic [15:0] wr_data_q;
    logic        rd_q;
    logic        rst_pad_q;
    logic        req;
    logic        accept;
    logic        unused_rwds_1;

    assign hyperram_io_clk      = clk;
    assign hyperram_rst_to_pad_ = rst_pad_q;
    assign req                  = sram_req | sram_rd;
    assign accept               = (state == S_IDLE) && rst_pad_q && req;
    assign ca_nxt = {sram_rd, 1'b0, 1'b1, 29'(sram_addr[ADDR_WIDTH-1:3]), 13'd0, sram_addr[2:0]};
    assign unused_rwds_1        = hyperram_rwds_from_pad_1;

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_CSSETUP;
            S_CSSETUP: state_nxt = S_CA;
            S_CA:      if (cnt == 16'd0) state_nxt = S_WAIT;
            S_WAIT:    if (cnt == 16'd0) state_nxt = rd_q ? S_RDATA : S_WDATA;
            S_WDATA:   state_nxt = S_RECOVER;
            S_RDATA:   if (hyperram_rwds_from_pad_0 || cnt == 16'd0) state_nxt = S_RECOVER;
            S_RECOVER: if (cnt == 16'd0) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sram_ready             = 1'b0;
        hyperram_clk           = 1'b0;
        hyperram_ce_to_pad_    = 1'b1;
        hyperram_dq_dir        = 1'b0;
        hyperram_rwds_dir      = 1'b0;
        hyperram_dq_to_pad_0   = 8'h00;
        hyperram_dq_to_pad_1   = 8'h00;
        hyperram_rwds_to_pad_0 = 1'b0;
        hyperram_rwds_to_pad_1 = 1'b0;
        case (state)
            S_IDLE:    sram_ready = rst_pad_q;
            S_CSSETUP: hyperram_ce_to_pad_ = 1'b0;
            S_CA: begin
                hyperram_ce_to_pad_  = 1'b0;
                hyperram_clk         = 1'b1;
                hyperram_dq_dir      = 1'b1;
                hyperram_dq_to_pad_0 = ca_q[47:40];
                hyperram_dq_to_pad_1 = ca_q[39:32];
            end
            S_WAIT, S_RDATA: begin
                hyperram_ce_to_pad_ = 1'b0;
                hyperram_clk        = 1'b1;
            end
            S_WDATA: begin
                hyperram_ce_to_pad_  = 1'b0;
                hyperram_clk         = 1'b1;
                hyperram_dq_dir      = 1'b1;
                hyperram_rwds_dir    = 1'b1;
                hyperram_dq_to_pad_0 = wr_data_q[15:8];
                hyperram_dq_to_pad_1 = wr_data_q[7:0];
            end
            default: ;
        endcase
    end

    // Down-counter is loaded on every state change with the remaining cycles of the new state.
    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            rst_pad_q        <= 1'b0;
            cnt              <= 16'd0;
            ca_q             <= 48'd0;
            wr_data_q        <= 16'd0;
            rd_q             <= 1'b0;
            sram_rd_data     <= 16'd0;
            sram_rd_data_vld <= 1'b0;
        end else begin
            rst_pad_q        <= 1'b1;
            sram_rd_data_vld <= 1'b0;
            if (accept) begin
                ca_q      <= ca_nxt;
                wr_data_q <= sram_wr_data;
                rd_q      <= sram_rd;
            end else if (state == S_CA) begin
                ca_q <= {ca_q[31:0], 16'd0};
            end
            if (state_nxt != state) begin
                case (state_nxt)
                    S_CA:      cnt <= 16'd2;
                    S_WAIT:    cnt <= 16'(2 * LATENCY - 1);
                    S_RDATA:   cnt <= 16'(RD_TIMEOUT - 1);
                    S_RECOVER: cnt <= 16'd1;
                    default:   cnt <= 16'd0;
                endcase
            end else if (cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
            end
            if (state == S_RDATA && hyperram_rwds_from_pad_0) begin
                sram_rd_data     <= {hyperram_dq_from_pad_0, hyperram_dq_from_pad_1};
                sram_rd_data_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hyperram_ctrl.sv
// Directed bench for hyperram_ctrl: vector table of single transactions plus hand-written
// sequences for reset, held requests and reset during the latency phase.
module tb_hyperram_ctrl;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset_ = 1'b1;
    logic          sram_req = 1'b0;
    logic          sram_rd = 1'b0;
    logic          sram_ready;
    logic [AW-1:0] sram_addr = '0;
    logic [15:0]   sram_wr_data = '0;
    logic          sram_rd_data_vld;
    logic [15:0]   sram_rd_data;
    logic          hyperram_io_clk;
    logic          hyperram_clk;
    logic          hyperram_ce_to_pad_;
    logic          hyperram_rst_to_pad_;
    logic          hyperram_dq_dir;
    logic          hyperram_rwds_dir;
    logic [7:0]    hyperram_dq_to_pad_0;
    logic [7:0]    hyperram_dq_to_pad_1;
    logic          hyperram_rwds_to_pad_0;
    logic          hyperram_rwds_to_pad_1;
    logic [7:0]    hyperram_dq_from_pad_0 = '0;
    logic [7:0]    hyperram_dq_from_pad_1 = '0;
    logic          hyperram_rwds_from_pad_0 = 1'b0;
    logic          hyperram_rwds_from_pad_1 = 1'b0;

    int checks = 0;
    int errors = 0;

    hyperram_ctrl #(.ADDR_WIDTH(AW), .LATENCY(6), .RD_TIMEOUT(16)) dut (
        .clk                      (clk),
        .reset_                   (reset_),
        .sram_req                 (sram_req),
        .sram_rd                  (sram_rd),
        .sram_ready               (sram_ready),
        .sram_addr                (sram_addr),
        .sram_wr_data             (sram_wr_data),
        .sram_rd_data_vld         (sram_rd_data_vld),
        .sram_rd_data             (sram_rd_data),
        .hyperram_io_clk          (hyperram_io_clk),
        .hyperram_clk             (hyperram_clk),
        .hyperram_ce_to_pad_      (hyperram_ce_to_pad_),
        .hyperram_rst_to_pad_     (hyperram_rst_to_pad_),
        .hyperram_dq_dir          (hyperram_dq_dir),
        .hyperram_rwds_dir        (hyperram_rwds_dir),
        .hyperram_dq_to_pad_0     (hyperram_dq_to_pad_0),
        .hyperram_dq_to_pad_1     (hyperram_dq_to_pad_1),
        .hyperram_rwds_to_pad_0   (hyperram_rwds_to_pad_0),
        .hyperram_rwds_to_pad_1   (hyperram_rwds_to_pad_1),
        .hyperram_dq_from_pad_0   (hyperram_dq_from_pad_0),
        .hyperram_dq_from_pad_1   (hyperram_dq_from_pad_1),
        .hyperram_rwds_from_pad_0 (hyperram_rwds_from_pad_0),
        .hyperram_rwds_from_pad_1 (hyperram_rwds_from_pad_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [11:0] addr;
        logic [15:0] wdata;
        int          rwds_at;   // RDATA cycle (0-based) carrying RWDS, -1 = never
        logic [7:0]  dq0;
        logic [7:0]  dq1;
        logic [47:0] ca;        // expected CA bytes in pad order
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ctl();
        return {hyperram_ce_to_pad_, hyperram_clk, hyperram_dq_dir, hyperram_rwds_dir};
    endfunction

    task automatic wait_ready(input int limit);
        int n = 0;
        while (!sram_ready && n < limit) begin
            tick();
            n++;
        end
        chk("ready_timeout", 48'(sram_ready), 48'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int vld_cnt = 0;
        int lim;
        chk("ready_pre", 48'(sram_ready), 48'd1);
        sram_rd      = v.rd;
        sram_req     = ~v.rd;
        sram_addr    = v.addr;
        sram_wr_data = v.wdata;
        tick();
        sram_req = 1'b0; sram_rd = 1'b0;
        sram_addr = '1; sram_wr_data = 16'hFFFF;
        chk("cssetup_ctl", 48'(ctl()), 48'(4'b0000));
        chk("cssetup_ready", 48'(sram_ready), 48'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ca_ctl", 48'(ctl()), 48'(4'b0110));
            chk("ca_pair", 48'({hyperram_dq_to_pad_0, hyperram_dq_to_pad_1}),
                48'(v.ca[47-16*k -: 16]));
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("wait_ctl", 48'(ctl()), 48'(4'b0100));
        end
        if (!v.rd) begin
            tick();
            chk("wdata_ctl", 48'(ctl()), 48'(4'b0111));
            chk("wdata_pair", 48'({hyperram_dq_to_pad_0, hyperram_dq_to_pad_1}), 48'(v.wdata));
            chk("wdata_rwds", 48'({hyperram_rwds_to_pad_0, hyperram_rwds_to_pad_1}), 48'd0);
        end else begin
            lim = (v.rwds_at < 0) ? 16 : v.rwds_at + 1;
            for (int j = 0; j < lim; j++) begin
                tick();
                chk("rdata_ctl", 48'(ctl()), 48'(4'b0100));
                vld_cnt += int'(sram_rd_data_vld);
                hyperram_rwds_from_pad_0 = (j == v.rwds_at);
                hyperram_rwds_from_pad_1 = (j == v.rwds_at);
                hyperram_dq_from_pad_0   = (j == v.rwds_at) ? v.dq0 : 8'hFF;
                hyperram_dq_from_pad_1   = (j == v.rwds_at) ? v.dq1 : 8'hEE;
            end
        end
        for (int r = 0; r < 2; r++) begin
            tick();
            hyperram_rwds_from_pad_0 = 1'b0;
            hyperram_rwds_from_pad_1 = 1'b0;
            hyperram_dq_from_pad_0   = 8'h5C;
            hyperram_dq_from_pad_1   = 8'hC5;
            chk("recover_ctl", 48'(ctl()), 48'(4'b1000));
            chk("recover_ready", 48'(sram_ready), 48'd0);
            vld_cnt += int'(sram_rd_data_vld);
        end
        tick();
        chk("ready_post", 48'(sram_ready), 48'd1);
        vld_cnt += int'(sram_rd_data_vld);
        chk("vld_count", 48'(vld_cnt), 48'((v.rd && v.rwds_at >= 0) ? 1 : 0));
        if (v.rd) chk("rd_data", 48'(sram_rd_data), 48'(v.exp_rd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int falls;
        int n;
        int bad;
        logic prev_ce;

        vecs[0] = '{1'b0, 12'h000, 16'hAA55, -1, 8'h00, 8'h00, 48'h2000_0000_0000, 16'h0000};
        vecs[1] = '{1'b1, 12'h00A, 16'h0000,  3, 8'h12, 8'h34, 48'hA000_0001_0002, 16'h1234};
        vecs[2] = '{1'b1, 12'hFFF, 16'h0000, -1, 8'h00, 8'h00, 48'hA000_01FF_0007, 16'h1234};
        vecs[3] = '{1'b0, 12'h5A3, 16'h1357, -1, 8'h00, 8'h00, 48'h2000_00B4_0003, 16'h0000};
        vecs[4] = '{1'b1, 12'h008, 16'h0000,  0, 8'hDE, 8'hAD, 48'hA000_0001_0000, 16'hDEAD};

        // reset state
        tick(); tick();
        chk("rst_ce", 48'(hyperram_ce_to_pad_), 48'd1);
        chk("rst_pad_reset", 48'(hyperram_rst_to_pad_), 48'd0);
        chk("rst_ready", 48'(sram_ready), 48'd0);
        chk("rst_ctl", 48'(ctl()), 48'(4'b1000));
        chk("rst_pads", 48'({hyperram_dq_to_pad_0, hyperram_dq_to_pad_1,
                             hyperram_rwds_to_pad_0, hyperram_rwds_to_pad_1}), 48'd0);
        chk("rst_rd", 48'({sram_rd_data_vld, sram_rd_data}), 48'd0);
        reset_ = 1'b0;
        tick();
        chk("rel_pad_reset", 48'(hyperram_rst_to_pad_), 48'd1);
        chk("rel_ready", 48'(sram_ready), 48'd1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // request held 10 cycles: exactly one write
        falls = 0;
        prev_ce = hyperram_ce_to_pad_;
        sram_req = 1'b1; sram_wr_data = 16'h0F0F; sram_addr = 12'h010;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (prev_ce && !hyperram_ce_to_pad_) falls++;
            prev_ce = hyperram_ce_to_pad_;
        end
        sram_req = 1'b0;
        n = 0;
        while (!sram_ready && n < 40) begin
            tick();
            if (prev_ce && !hyperram_ce_to_pad_) falls++;
            prev_ce = hyperram_ce_to_pad_;
            n++;
        end
        chk("held_one_write", 48'(falls), 48'd1);
        chk("held_ready", 48'(sram_ready), 48'd1);

        // continuous request: ready at N+20, next write starts right away
        sram_req = 1'b1;
        tick();
        n = 1;
        while (!sram_ready && n < 40) begin
            tick();
            n++;
        end
        chk("ready_cycle", 48'(n), 48'd20);
        tick();
        chk("second_start", 48'({hyperram_ce_to_pad_, sram_ready}), 48'd0);
        sram_req = 1'b0;
        wait_ready(40);

        // reset asserted during WAIT
        sram_req = 1'b1; sram_wr_data = 16'hBEEF;
        tick();
        sram_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_rst_wait", 48'(ctl()), 48'(4'b0100));
        reset_ = 1'b1;
        #1;
        chk("midrst_ctl", 48'(ctl()), 48'(4'b1000));
        chk("midrst_pad_reset", 48'(hyperram_rst_to_pad_), 48'd0);
        tick();
        reset_ = 1'b0;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (hyperram_rwds_dir || sram_rd_data_vld || !hyperram_ce_to_pad_) bad++;
        end
        chk("midrst_no_data", 48'(bad), 48'd0);
        chk("midrst_ready", 48'(sram_ready), 48'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
